// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock via trial subtraction
// of the divisor from a left-shifting partial remainder, with a start/busy/done handshake.
module restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  dvsr_q, dvsr_d;
    // The partial remainder is always < divisor between steps, so its top bit is
    // only needed transiently inside the trial subtraction.
    logic [WIDTH-1:0]  p_q, p_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvsr_d  = dvsr_q;
        p_d     = p_q;
        q_d     = q_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        shifted = '0;
        trial   = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = StDone;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                        dvsr_d  = divisor;
                        p_d     = '0;
                        q_d     = dividend;
                        cnt_d   = CntW'(WIDTH);
                        dbz_d   = 1'b0;
                    end
                end
            end
            StRun: begin
                shifted = {1'b0, p_q[WIDTH-2:0], q_q[WIDTH-1]};
                shifted[WIDTH] = p_q[WIDTH-1];
                trial   = shifted - {1'b0, dvsr_q};
                if (!trial[WIDTH]) begin
                    p_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = shifted[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    quot_d  = q_d;
                    rem_d   = p_d;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvsr_q  <= '0;
            p_q     <= '0;
            q_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvsr_q  <= dvsr_d;
            p_q     <= p_d;
            q_q     <= q_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Sequential unsigned integer divider. It produces one quotient bit per clock by repeated trial subtraction, using the same minuend-minus-subtrahend operation as the team's combinational subtractor, applied to a shifting partial remainder. It sits downstream of the operand registers in the arithmetic datapath. It uses a start/busy/done handshake, and results are held stable until the next accepted start.

Parameters:
WIDTH, 8, bit width of dividend, divisor, quotient and remainder (legal values >= 2)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a division; sampled on a rising edge, accepted only in IDLE
dividend  input  WIDTH  unsigned dividend; captured on the accepting edge
divisor  input  WIDTH  unsigned divisor; captured on the accepting edge
busy  output  1  high while a division is in progress (RUN state)
done  output  1  one-cycle pulse when quotient and remainder become valid
quotient  output  WIDTH  unsigned quotient; holds its last value until the next completion
remainder  output  WIDTH  unsigned remainder; holds its last value until the next completion
div_by_zero  output  1  set at completion if the captured divisor was 0; cleared on the next accepted start

Behaviour:
- Reset: rst_n low asynchronously forces state to IDLE and all outputs to 0 (busy, done, quotient, remainder, div_by_zero), plus all internal registers and the iteration counter. This takes effect immediately, including in the middle of a division, and aborts it. There is no done pulse after a reset.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: start=1 and captured divisor != 0 at edge E0.
  - Latch divisor.
  - Partial remainder P (WIDTH+1 bits) = 0.
  - Working quotient Q = dividend.
  - Counter = WIDTH.
  - Clear div_by_zero.
- IDLE -> DONE: start=1 and divisor == 0 at edge E0.
  - quotient <= all ones, remainder <= dividend, div_by_zero <= 1.
- RUN, each edge:
  - {P,Q} shifts left by 1.
  - T = P_shifted - {0,divisor}, computed at WIDTH+1 bits.
  - If the MSB of T is 0 (non-negative): P <= T and Q LSB <= 1. Otherwise P keeps the shifted value and Q LSB <= 0.
  - Counter decrements by 1.
- RUN -> DONE: on the edge that performs the final iteration (counter was 1).
  - Same edge: quotient <= final Q, remainder <= final P[WIDTH-1:0].
- DONE -> IDLE: unconditionally on the next edge. done is high only in DONE, so it is exactly one cycle wide.
- busy = (state == RUN). busy is low in IDLE and DONE.
- Latency:
  - Normal case: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after the accepting edge.
  - Divide-by-zero: done is high in the cycle after E0, i.e. 1 cycle.
- Start acceptance:
  - start is ignored in RUN and DONE; it is not queued.
  - A start held high through DONE is accepted on the edge that returns to IDLE... no: the DONE -> IDLE edge is not an accepting edge. Acceptance happens on the first edge at which the state is already IDLE.
- Operands are captured only on the accepting edge. Changes to dividend or divisor during RUN have no effect.
- Output stability: quotient, remainder and div_by_zero change only at a completion edge (or at reset). They hold their values through IDLE and through subsequent RUN cycles.
- Arithmetic: all unsigned; no signed interpretation.
  - The trial subtraction never loses a borrow because of its WIDTH+1 width.
  - Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
- Boundary cases:
  - dividend < divisor gives quotient 0, remainder = dividend.
  - dividend = 0 gives 0, 0.
  - divisor = 1 gives quotient = dividend, remainder 0.

Test Plan:
- WIDTH=8, start with 100/7 -> busy high for 8 cycles; done pulses once, 8 cycles after the accepting edge; quotient=14, remainder=2, div_by_zero=0.
- 255/1, then 5/9, then 0/3 back-to-back (each start issued in IDLE) -> (255,0), (0,5), (0,0); outputs stay stable between done pulses.
- 77/0 -> done pulses 1 cycle after the accepting edge with busy never high; quotient=8'hFF, remainder=77, div_by_zero=1. A following 9/3 clears div_by_zero and yields (3,0).
- Start 200/13, then at cycle 3 pulse start again and change dividend to 50 and divisor to 2 -> second start ignored; result (15,5); exactly one done pulse.
- Start 200/13, drive rst_n low asynchronously mid-cycle during RUN cycle 4 -> all outputs 0 immediately, no done pulse. After release, 42/5 -> (8,2).
- Random sweep of 1000 pairs (including divisor 0 and 255) -> every result matches the reference model, and done latency is always 8 (or 1 for divisor 0).
